// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame clocked by the device, ACK check.
// States: IDLE wait start | INHIBIT hold clock low | REQ start bit, release clock | SEND bits on device edges | ACK sample ack | WAITIDLE lines high | DONE completion pulse
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic       rx_inhibit,
  input  logic       KB_CLK_IN,
  input  logic       KB_DATA_IN,
  output logic       KB_CLK_OE,
  output logic       KB_DATA_OE
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_TC = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_TC  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAITIDLE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            nack_q, nack_d;
  logic            err_q, err_d;
  logic            clk_meta_q, clk_sync_q, clk_prev_q;
  logic            data_meta_q, data_sync_q;
  logic            fe;
  logic            tc_hit;

  // Synchronisers reset high so the idle bus never looks like a falling edge
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= KB_CLK_IN;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= KB_DATA_IN;
      data_sync_q <= data_meta_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      bitcnt_q  <= '0;
      cnt_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      nack_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      bitcnt_q  <= bitcnt_d;
      cnt_q     <= cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      nack_q    <= nack_d;
      err_q     <= err_d;
    end
  end

  assign fe     = clk_prev_q & ~clk_sync_q;
  assign tc_hit = (cnt_q == TO_TC);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    bitcnt_d  = bitcnt_q;
    cnt_d     = cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    nack_d    = nack_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_start) begin
          shreg_d  = tx_data;
          par_d    = ~^tx_data;
          clk_oe_d = 1'b1;
          cnt_d    = '0;
          err_d    = 1'b0;
          nack_d   = 1'b0;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == INH_TC) begin
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        clk_oe_d = 1'b0;
        bitcnt_d = '0;
        cnt_d    = '0;
        state_d  = S_SEND;
      end
      S_SEND, S_ACK, S_WAITIDLE: begin
        // An edge always beats the timeout terminal count
        if (state_q == S_WAITIDLE && clk_sync_q && data_sync_q) begin
          err_d   = nack_q;
          state_d = S_DONE;
        end else if (fe) begin
          cnt_d    = '0;
          bitcnt_d = bitcnt_q + 1'b1;
          if (state_q == S_SEND) begin
            if (bitcnt_q < 4'd8) begin
              data_oe_d = ~shreg_q[bitcnt_q[2:0]];
            end else if (bitcnt_q == 4'd8) begin
              data_oe_d = ~par_q;
            end else begin
              data_oe_d = 1'b0;
              state_d   = S_ACK;
            end
          end else if (state_q == S_ACK) begin
            nack_d  = data_sync_q;
            state_d = S_WAITIDLE;
          end
        end else if (tc_hit) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  assign tx_busy    = (state_q != S_IDLE);
  assign rx_inhibit = tx_busy;
  assign tx_done    = (state_q == S_DONE);
  assign tx_err     = err_q;
  assign KB_CLK_OE  = clk_oe_q;
  assign KB_DATA_OE = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: wired-AND bus with a PS/2 device model and a frame scoreboard.
module tb_ps2_host_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_err, rx_inhibit;
  logic       KB_CLK_OE, KB_DATA_OE;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       kb_clk, kb_data;

  assign kb_clk  = ~(KB_CLK_OE | dev_clk_low);
  assign kb_data = ~(KB_DATA_OE | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(500)) dut (
    .CLK(CLK), .RST(RST), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err), .rx_inhibit(rx_inhibit),
    .KB_CLK_IN(kb_clk), .KB_DATA_IN(kb_data),
    .KB_CLK_OE(KB_CLK_OE), .KB_DATA_OE(KB_DATA_OE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [10:0] bits;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic err_at_done = 1'b0;
  int run = 0, lead = 0, last_run = 0, last_lead = 0;

  always @(negedge CLK) begin
    if (tx_done) begin
      done_cnt    <= done_cnt + 1;
      err_at_done <= tx_err;
    end
    if (KB_CLK_OE) begin
      run <= run + 1;
      if (KB_DATA_OE) lead <= lead + 1;
    end else if (run != 0) begin
      last_run  <= run;
      last_lead <= lead;
      run  <= 0;
      lead <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] d);
    @(negedge CLK);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge CLK);
    tx_start = 1'b0;
    check("start_busy", tx_busy, 1);
    check("start_clk_oe", KB_CLK_OE, 1);
    check("start_err_clr", tx_err, 0);
  endtask

  task automatic wait_req(output bit ok);
    int t = 0;
    while (!(kb_clk == 1'b1 && kb_data == 1'b0) && t < 2000) begin
      @(negedge CLK);
      t++;
    end
    ok = (t < 2000);
    repeat (10) @(negedge CLK);
  endtask

  task automatic dev_bit(output logic b);
    dev_clk_low = 1'b1;
    repeat (20) @(negedge CLK);
    b = kb_data;
    dev_clk_low = 1'b0;
    repeat (20) @(negedge CLK);
  endtask

  task automatic dev_frame(input bit ack, output logic [10:0] bits, output bit ok);
    logic b;
    bits = '0;
    wait_req(ok);
    if (!ok) return;
    bits[0] = kb_data;
    for (int i = 1; i <= 10; i++) begin
      dev_bit(b);
      bits[i] = b;
    end
    if (ack) dev_data_low = 1'b1;
    repeat (5) @(negedge CLK);
    dev_bit(b);
    dev_data_low = 1'b0;
  endtask

  function automatic exp_t make_exp(input logic [7:0] d, input bit ack);
    exp_t e;
    e.bits = {1'b1, ~^d, d, 1'b0};
    e.err  = ~ack;
    return e;
  endfunction

  task automatic finish_frame(input logic [10:0] got, input bit ok, input int d0);
    exp_t e;
    int w = 0;
    check("req_seen", ok, 1);
    while (done_cnt == d0 && w < 200) begin
      @(negedge CLK);
      w++;
    end
    check("done_seen", (done_cnt != d0), 1);
    e = sb.pop_front();
    check("frame_bits", got, e.bits);
    check("err_at_done", err_at_done, e.err);
    repeat (50) @(negedge CLK);
    check("one_done", done_cnt - d0, 1);
    check("idle_busy", tx_busy, 0);
    check("clk_oe_len", last_run, 21);
    check("start_lead", last_lead, 1);
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack);
    logic [10:0] got;
    bit ok;
    int d0 = done_cnt;
    sb.push_back(make_exp(d, ack));
    start(d);
    dev_frame(ack, got, ok);
    finish_frame(got, ok, d0);
  endtask

  initial begin
    logic [10:0] got;
    logic b;
    bit ok;
    int d0, t;

    #22;
    check("rst_clk_oe", KB_CLK_OE, 0);
    check("rst_data_oe", KB_DATA_OE, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_err", tx_err, 0);
    check("rst_inhibit", rx_inhibit, 0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);

    run_frame(8'hED, 1'b1);
    run_frame(8'hFF, 1'b1);
    run_frame(8'h00, 1'b0);

    // device never clocks
    start(8'hA5);
    t = 0;
    while (KB_CLK_OE && t < 100) begin
      @(negedge CLK);
      t++;
    end
    t = 0;
    while (!tx_done && t < 1000) begin
      @(negedge CLK);
      t++;
    end
    check("to_latency", t, 500);
    check("to_done", tx_done, 1);
    check("to_err", tx_err, 1);
    check("to_clk_oe", KB_CLK_OE, 0);
    check("to_data_oe", KB_DATA_OE, 0);
    @(negedge CLK);
    check("to_busy_fall", tx_busy, 0);
    repeat (5) @(negedge CLK);

    // start while busy is ignored
    d0 = done_cnt;
    sb.push_back(make_exp(8'hF4, 1'b1));
    start(8'hF4);
    fork
      dev_frame(1'b1, got, ok);
      begin
        repeat (200) @(negedge CLK);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge CLK);
        tx_start = 1'b0;
      end
    join
    finish_frame(got, ok, d0);

    // reset mid-frame after edge 5
    d0 = done_cnt;
    start(8'hF4);
    wait_req(ok);
    check("rst_req_seen", ok, 1);
    for (int i = 0; i < 5; i++) dev_bit(b);
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    check("mid_rst_clk_oe", KB_CLK_OE, 0);
    check("mid_rst_data_oe", KB_DATA_OE, 0);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_inhibit", rx_inhibit, 0);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    check("mid_rst_no_done", done_cnt - d0, 0);
    run_frame(8'hF4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
